// File: rtl/ssd_capture.sv
// ssd_capture
// Receive side of a multiplexed 4-digit MM:SS seven-segment bus. It snoops the
// anode strobes and segment cathodes. Each (an,seg) pair that stays stable long
// enough is decoded back to BCD and checked. Once all four positions have been
// captured, a complete time value is published.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   an[3:0]      anode strobes, active-low (0=sec units, 1=sec tens,
//                2=min units, 3=min tens)
//   seg[6:0]     cathodes, active-low, seg[6]=CA ... seg[0]=CG
//   value[15:0]  {min_tens,min_units,sec_tens,sec_units}; 4'hF = blank digit
//   frame_valid  one-cycle pulse when value has just been refreshed
//   code_err     one-cycle pulse after an illegal pattern was accepted
//   stale        level; no accept for TIMEOUT cycles, cleared by frame_valid
module ssd_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 2**20,
   parameter int TO_W          = 21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic        code_err,
   output logic        stale
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {WAIT, SETTLE, LATCHED} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [3:0]       an_r, an_p;
   logic [6:0]       seg_r, seg_p;
   logic             an_ok, same, accept;
   logic [1:0]       pos;
   logic [3:0]       dec;
   logic             dec_ok;
   logic [3:0][3:0]  digit;
   logic [3:0]       seen;
   logic [TO_W-1:0]  to_cnt;
   logic             frame_done;

   // Input register plus a one-cycle history. The previous sample is compared
   // with the current one to detect a stable run. The reset value is the
   // blanked bus, so no stale sample can look like a valid digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r  <= 4'hF;
         seg_r <= 7'h7F;
         an_p  <= 4'hF;
         seg_p <= 7'h7F;
      end else begin
         an_r  <= an;
         seg_r <= seg;
         an_p  <= an_r;
         seg_p <= seg_r;
      end
   end

   // Exactly one anode low selects a position; blanking or multi-hot does not.
   always_comb begin
      an_ok = 1'b1;
      pos   = 2'd0;
      case (an_r)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: an_ok = 1'b0;
      endcase
   end

   always_comb begin
      dec    = 4'h0;
      dec_ok = 1'b1;
      case (seg_r)
         7'b0000001: dec = 4'd0;
         7'b1001111: dec = 4'd1;
         7'b0010010: dec = 4'd2;
         7'b0000110: dec = 4'd3;
         7'b1001100: dec = 4'd4;
         7'b0100100: dec = 4'd5;
         7'b0100000: dec = 4'd6;
         7'b0001111: dec = 4'd7;
         7'b0000000: dec = 4'd8;
         7'b0000100: dec = 4'd9;
         7'b1111111: dec = 4'hF;
         default:    dec_ok = 1'b0;
      endcase
      // Tens positions (odd index) only ever show 0..5 or blank.
      if (pos[0] && dec >= 4'd6 && dec <= 4'd9) dec_ok = 1'b0;
   end

   assign same = (an_r == an_p) && (seg_r == seg_p);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WAIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // The count holds the number of identical samples seen so far. The accept
   // fires on the sample that brings the count to STABLE_CYCLES. The count then
   // parks at STABLE_CYCLES in LATCHED, so a run can never accept twice.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      case (state)
         WAIT: begin
            if (an_ok) begin
               state_nx = SETTLE;
               cnt_nx   = CW'(1);
            end
         end
         SETTLE: begin
            if (!same) begin
               if (an_ok) begin
                  cnt_nx = CW'(1);
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = '0;
               end
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
               accept   = 1'b1;
               cnt_nx   = CW'(STABLE_CYCLES);
               state_nx = LATCHED;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         LATCHED: begin
            if (!same) begin
               if (an_ok) begin
                  state_nx = SETTLE;
                  cnt_nx   = CW'(1);
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = '0;
               end
            end
         end
         default: begin
            state_nx = WAIT;
            cnt_nx   = '0;
         end
      endcase
   end

   // seen only reaches all-ones through an accept. So seen==4'hF means the
   // previous edge completed a frame, and this edge publishes it.
   assign frame_done = (seen == 4'hF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit       <= '0;
         seen        <= '0;
         value       <= '0;
         frame_valid <= 1'b0;
         code_err    <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         code_err    <= accept && !dec_ok;
         if (frame_done) value <= digit;
         if (accept && dec_ok) digit[pos] <= dec;
         seen <= (frame_done ? 4'h0 : seen) |
                 ((accept && dec_ok) ? (4'b0001 << pos) : 4'h0);
      end
   end

   // Both legal and illegal accepts show that the bus is alive, so both clear
   // the counter. stale is raised on the edge where the counter lands on
   // TIMEOUT. An accept in that cycle clears the counter first, so stale is
   // not raised then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
         stale  <= 1'b0;
      end else begin
         if (accept)
            to_cnt <= '0;
         else if (to_cnt != TO_W'(TIMEOUT))
            to_cnt <= to_cnt + TO_W'(1);
         if (frame_done)
            stale <= 1'b0;
         else if (!accept && to_cnt == TO_W'(TIMEOUT - 1))
            stale <= 1'b1;
      end
   end

endmodule
